minimig_bank_decoder: RTL and testbench
=======================================

# minimig_bank_decoder

Consumer side of the Amiga bank-select bus: accepts a CPU/DMA access carrying an 8-bit one-hot bank select plus a word offset within a 512 KB block, and turns it into a physical-RAM request on the memory controller port using a req/ack handshake. It sits between the bank mapping logic and the SDRAM/SRAM controller. It also produces the bus-side acknowledge, read data, unmapped (open-bus) responses, and error responses for illegal or timed-out accesses.

## Interface
- OFFS_W, 18, word-offset width inside one 512 KB block
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..65535)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- bus_req  in  1  access request, level, held until bus_ack
- bus_we  in  1  1 = write
- bus_bs  in  2  byte selects {upper, lower}
- bus_offs  in  OFFS_W  word offset in block
- bus_wdata  in  16  write data
- bank  in  8  one-hot block select, bit i = physical block i
- bus_ack  out  1  one-cycle completion pulse
- bus_err  out  1  qualifies bus_ack: access failed
- bus_rdata  out  16  read data, valid with bus_ack, held until next completion
- mem_req  out  1  memory request, level
- mem_we  out  1  write
- mem_be  out  2  byte enables
- mem_addr  out  3+OFFS_W  {block index, offset}
- mem_wdata  out  16  write data
- mem_ack  in  1  one-cycle completion from controller; read data valid same cycle
- mem_rdata  in  16  read data

## Operation
- States: IDLE, ISSUE, RESP, RELEASE.
- IDLE: on bus_req=1, capture bus_we, bus_bs, bus_offs, bus_wdata, bank. Classify bank:
  - exactly one bit set -> block index = bit position; go ISSUE.
  - zero bits set (unmapped) -> go RESP with bus_rdata=16'hFFFF, bus_err=0; no memory access.
  - more than one bit set -> go RESP with bus_err=1, bus_rdata unchanged; no memory access.
- ISSUE: mem_req=1 with captured fields on mem_*; all mem_* outputs stable while mem_req=1. On mem_ack: capture mem_rdata into bus_rdata if read (writes leave bus_rdata unchanged), drop mem_req, go RESP. Timeout counter counts ISSUE cycles; after TIMEOUT cycles with no ack, drop mem_req, bus_err=1, go RESP.
- RESP: bus_ack=1 for one cycle (bus_err as determined), go RELEASE.
- RELEASE: wait for bus_req=0, then IDLE. A new access requires bus_req to deassert first.
- bus_bs=2'b00: still performed (mem_be=00), controller decides.
- mem_ack outside ISSUE is ignored (late ack after timeout must not corrupt bus_rdata or generate bus_ack).
- Reset (any time, including mid-ISSUE): state IDLE, all outputs 0 (bus_rdata=16'h0000, mem_addr=0), timeout counter 0; a pending memory access is abandoned.

## Timing
- bus_req sampled high in IDLE at edge N -> mem_req high from N+1.
- mem_ack high at edge M -> mem_req low from M+1, bus_ack high for cycle M+1 only.
- Best-case mapped access: bus_req to bus_ack = 2 cycles + controller latency; unmapped/illegal: bus_ack at N+1.
- Timeout: mem_req held exactly TIMEOUT cycles; if mem_ack arrives on the final counted cycle, ack wins (no error).
- bus_ack/bus_err are registered; no combinational path from bus_* or mem_ack to any output.

## Structure
- Shared package minimig_mem_pkg: state enum, BLOCK_W=3, OPEN_BUS=16'hFFFF, bank width 8.
- Sub-module minimig_bank_encoder: combinational one-hot -> {index[2:0], none, multi}; reused by other memory-side blocks.

## Test plan
- Read, bank=8'h04, offs=18'h00010, controller acks after 3 cycles with 16'hBEEF -> mem_addr={3'd2,18'h00010}, mem_be=bus_bs, bus_ack one cycle with bus_rdata=16'hBEEF, bus_err=0.
- Write, bank=8'h80, bs=2'b10, wdata=16'h1234 -> mem_we=1, mem_addr upper bits 3'd7, mem_be=2'b10, mem_wdata=16'h1234; bus_rdata unchanged after ack.
- bank=8'h00 read -> no mem_req, bus_ack at N+1, bus_rdata=16'hFFFF, bus_err=0; bank=8'h05 -> no mem_req, bus_ack with bus_err=1.
- TIMEOUT=8, controller never acks -> mem_req high exactly 8 cycles, bus_ack+bus_err; later stray mem_ack ignored, bus_rdata unchanged.
- bus_req held high after bus_ack -> no second access until bus_req low for ≥1 cycle; back-to-back accesses then complete correctly.
- rst_n asserted mid-ISSUE -> mem_req and all outputs 0 immediately (asynchronously); after release, new access completes normally.

Source files
------------

// File: rtl/minimig_mem_pkg.sv
// Shared definitions for the memory-side blocks behind the Amiga bank-select bus.
package minimig_mem_pkg;
  localparam int          BLOCK_W  = 3;
  localparam int          BANK_W   = 8;
  localparam logic [15:0] OPEN_BUS = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    RELEASE
  } bd_state_e;
endpackage

// File: rtl/minimig_bank_encoder.sv
// One-hot bank select to block index, with flags for no bank and several banks.
module minimig_bank_encoder
  import minimig_mem_pkg::*;
(
  input  logic [BANK_W-1:0]  bank,
  output logic [BLOCK_W-1:0] idx,
  output logic               none,
  output logic               multi
);
  always_comb begin
    idx   = '0;
    none  = 1'b1;
    multi = 1'b0;
    for (int i = 0; i < BANK_W; i++) begin
      if (bank[i]) begin
        if (!none) multi = 1'b1;
        none = 1'b0;
        idx  = BLOCK_W'(i);
      end
    end
  end
endmodule

// File: rtl/minimig_bank_decoder.sv
// Bank-select bus consumer: turns a one-hot block access into a req/ack memory request.
module minimig_bank_decoder
  import minimig_mem_pkg::*;
#(
  parameter int OFFS_W  = 18,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bus_req,
  input  logic                      bus_we,
  input  logic [1:0]                bus_bs,
  input  logic [OFFS_W-1:0]         bus_offs,
  input  logic [15:0]               bus_wdata,
  input  logic [BANK_W-1:0]         bank,
  output logic                      bus_ack,
  output logic                      bus_err,
  output logic [15:0]               bus_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [1:0]                mem_be,
  output logic [BLOCK_W+OFFS_W-1:0] mem_addr,
  output logic [15:0]               mem_wdata,
  input  logic                      mem_ack,
  input  logic [15:0]               mem_rdata
);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  logic [BLOCK_W-1:0] idx;
  logic               none;
  logic               multi;
  bd_state_e          state;
  logic [15:0]        tcnt;

  minimig_bank_encoder u_enc (
    .bank (bank),
    .idx  (idx),
    .none (none),
    .multi(multi)
  );

  // mem_* registers double as the captured request, so they stay stable while mem_req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      bus_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_req) begin
            if (multi) begin
              bus_ack <= 1'b1;
              bus_err <= 1'b1;
              state   <= RESP;
            end else if (none) begin
              bus_ack   <= 1'b1;
              bus_rdata <= OPEN_BUS;
              state     <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= bus_we;
              mem_be    <= bus_bs;
              mem_addr  <= {idx, bus_offs};
              mem_wdata <= bus_wdata;
              tcnt      <= '0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // An ack on the last counted cycle still beats the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) bus_rdata <= mem_rdata;
            bus_ack <= 1'b1;
            state   <= RESP;
          end else if (tcnt == TLAST) begin
            mem_req <= 1'b0;
            bus_ack <= 1'b1;
            bus_err <= 1'b1;
            state   <= RESP;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        RESP:    state <= RELEASE;
        RELEASE: if (!bus_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minimig_bank_decoder.sv
// Scoreboard bench for minimig_bank_decoder: bus responses queued at drive time, popped on bus_ack.
module tb_minimig_bank_decoder;
  localparam int OFFS_W  = 18;
  localparam int TIMEOUT = 8;
  localparam int AW      = 3 + OFFS_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bus_req = 1'b0;
  logic              bus_we = 1'b0;
  logic [1:0]        bus_bs = '0;
  logic [OFFS_W-1:0] bus_offs = '0;
  logic [15:0]       bus_wdata = '0;
  logic [7:0]        bank = '0;
  logic              bus_ack;
  logic              bus_err;
  logic [15:0]       bus_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [AW-1:0]     mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  minimig_bank_decoder #(.OFFS_W(OFFS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_req(bus_req), .bus_we(bus_we), .bus_bs(bus_bs), .bus_offs(bus_offs),
    .bus_wdata(bus_wdata), .bank(bank),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int          checks = 0;
  int          errors = 0;
  logic [16:0] sbq[$];
  logic [16:0] sb_e;
  logic [15:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_ack) begin
      if (sbq.size() == 0) chk("spur_ack", 32'(bus_ack), 0);
      else begin
        sb_e = sbq.pop_front();
        chk("resp", {bus_err, bus_rdata}, sb_e);
      end
    end
  end

  // lat < 0: controller never acks. hold: cycles bus_req stays high after bus_ack.
  task automatic access(input logic we, input logic [1:0] bs, input logic [OFFS_W-1:0] offs,
                        input logic [15:0] wd, input logic [7:0] bk, input int lat,
                        input logic [15:0] rd, input int hold);
    int   ones, idx, n;
    logic err;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < 8; i++) if (bk[i]) begin ones++; idx = i; end
    err = (ones > 1) || (ones == 1 && lat < 0);
    if (ones == 0) m_rdata = 16'hFFFF;
    else if (ones == 1 && lat >= 0 && !we) m_rdata = rd;
    sbq.push_back({err, m_rdata});
    @(posedge clk); #1;
    bus_we = we; bus_bs = bs; bus_offs = offs; bus_wdata = wd; bank = bk; bus_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (ones == 1) begin
      chk("mreq_on", 32'(mem_req), 1);
      chk("maddr", 32'(mem_addr), 32'({3'(idx), offs}));
      chk("mbe", 32'(mem_be), 32'(bs));
      chk("mwe", 32'(mem_we), 32'(we));
      if (we) chk("mwdata", 32'(mem_wdata), 32'(wd));
      if (lat >= 0) begin
        repeat (lat) begin
          @(negedge clk);
          chk("mreq_hold", {mem_req, mem_addr}, {1'b1, 3'(idx), offs});
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h5A5A;
        chk("mreq_off", 32'(mem_req), 0);
      end else begin
        n = 1;
        while (mem_req && n <= 200) begin
          @(negedge clk);
          if (mem_req) n++;
        end
        chk("to_len", n, TIMEOUT);
      end
    end else begin
      chk("mreq_none", 32'(mem_req), 0);
    end
    chk("ack_on", 32'(bus_ack), 1);
    repeat (hold) begin
      @(negedge clk);
      chk("no_reacc", {mem_req, bus_ack}, 0);
    end
    bus_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bk;
    #12;
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_rdata", 32'(bus_rdata), 0);
    chk("rst_mreq", 32'(mem_req), 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    @(negedge clk); rst_n = 1'b1;

    access(1'b0, 2'b11, 18'h00010, 16'h0000, 8'h04, 3, 16'hBEEF, 2);
    access(1'b1, 2'b10, 18'h2AAAA, 16'h1234, 8'h80, 1, 16'hDEAD, 3);
    access(1'b0, 2'b11, 18'h00001, 16'h0000, 8'h00, 0, 16'h0000, 1);
    access(1'b0, 2'b01, 18'h00002, 16'h0000, 8'h05, 0, 16'h0000, 1);
    access(1'b0, 2'b11, 18'h00003, 16'h0000, 8'h01, -1, 16'h0000, 2);
    // late ack after the timeout must be ignored
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_rd", 32'(bus_rdata), 32'(m_rdata));
    chk("stray_req", 32'(mem_req), 0);
    access(1'b0, 2'b11, 18'h3FFFF, 16'h0000, 8'h02, TIMEOUT - 1, 16'hA5A5, 1);
    access(1'b1, 2'b00, 18'h00100, 16'hCAFE, 8'h10, 0, 16'h7777, 1);
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       bk = 8'h00;
        1:       bk = 8'h03 << $urandom_range(0, 6);
        default: bk = 8'h01 << $urandom_range(0, 7);
      endcase
      access(1'($urandom), 2'($urandom), 18'($urandom), 16'($urandom), bk,
             $urandom_range(0, 5), 16'($urandom), $urandom_range(1, 3));
    end

    // asynchronous reset in the middle of an ISSUE
    @(posedge clk); #1;
    bus_we = 1'b0; bus_bs = 2'b11; bus_offs = 18'h12345; bank = 8'h08; bus_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mreq", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mreq", 32'(mem_req), 0);
    chk("arst_rdata", 32'(bus_rdata), 0);
    chk("arst_maddr", 32'(mem_addr), 0);
    chk("arst_ack", {bus_ack, bus_err, mem_we, mem_be, mem_wdata}, 0);
    m_rdata = '0;
    bus_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    access(1'b0, 2'b01, 18'h00042, 16'h0000, 8'h40, 2, 16'h4242, 1);
    access(1'b0, 2'b11, 18'h00043, 16'h0000, 8'h00, 0, 16'h0000, 1);

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
